// File: rtl/serial_adder4.sv
// serial_adder4 -- bit-serial ripple adder with a result handshake.
//
// Purpose:
//   Captures two WIDTH-bit operands and a carry-in on a start request, adds
//   them one bit per clock (LSB first) and presents {c_out,sum} with valid
//   until the downstream stage acknowledges the result.
//
// Ports:
//   clk    in   1      single clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      add request, sampled only in IDLE
//   a      in   WIDTH  operand A
//   b      in   WIDTH  operand B
//   c_in   in   1      carry into bit 0
//   ack    in   1      downstream acceptance, sampled only in HOLD
//   busy   out  1      high in ADD or HOLD
//   valid  out  1      high in HOLD; sum/c_out are the current result
//   sum    out  WIDTH  registered result
//   c_out  out  1      registered final carry

module serial_adder4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] aShift_q;
  logic [WIDTH-1:0] bShift_q;
  logic             carry_q;
  logic [WIDTH-1:0] sumShift_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] sum_q;
  logic             cOut_q;
  logic             busy_q;
  logic             valid_q;

  logic             bitSum_d;
  logic             carry_d;
  logic [WIDTH-1:0] sumShift_d;
  logic             lastBit_d;

  // One full-adder slice working on the LSBs of the operand shift registers.
  // The new sum bit enters at the MSB so that after WIDTH shifts the first
  // bit computed has reached bit 0.
  always_comb begin
    bitSum_d   = aShift_q[0] ^ bShift_q[0] ^ carry_q;
    carry_d    = (aShift_q[0] & bShift_q[0]) |
                 (aShift_q[0] & carry_q)     |
                 (bShift_q[0] & carry_q);
    sumShift_d = {bitSum_d, sumShift_q[WIDTH-1:1]};
    lastBit_d  = (count_q == CW'(WIDTH - 1));
  end

  // Control FSM and datapath registers. busy/valid are registered alongside
  // the state so they never glitch; sum/c_out load only on the final ADD edge
  // and otherwise keep the previous result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      aShift_q   <= '0;
      bShift_q   <= '0;
      carry_q    <= 1'b0;
      sumShift_q <= '0;
      count_q    <= '0;
      sum_q      <= '0;
      cOut_q     <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            aShift_q <= a;
            bShift_q <= b;
            carry_q  <= c_in;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= ADD;
          end
        end
        ADD: begin
          aShift_q   <= aShift_q >> 1;
          bShift_q   <= bShift_q >> 1;
          carry_q    <= carry_d;
          sumShift_q <= sumShift_d;
          count_q    <= count_q + CW'(1);
          if (lastBit_d) begin
            sum_q   <= sumShift_d;
            cOut_q  <= carry_d;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          // ack wins over start here; a new request needs start seen in IDLE.
          if (ack) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign sum   = sum_q;
  assign c_out = cOut_q;

endmodule

// File: doc/serial_adder4.md
SERIAL_ADDER4 -- requirements
Module: serial_adder4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the operand and sum width in bits.
REQ-002 Port clk SHALL be an input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit; reset is asynchronous and active-low.
REQ-004 Port start SHALL be an input, 1 bit, requesting an addition; it is sampled only in IDLE.
REQ-005 Port a SHALL be an input, WIDTH bits, operand A.
REQ-006 Port b SHALL be an input, WIDTH bits, operand B.
REQ-007 Port c_in SHALL be an input, 1 bit, the carry into bit 0.
REQ-008 Port ack SHALL be an input, 1 bit, the downstream acceptance of the result.
REQ-009 Port busy SHALL be an output, 1 bit, high while in ADD or HOLD.
REQ-010 Port valid SHALL be an output, 1 bit, high while in HOLD, meaning sum and c_out are valid.
REQ-011 Port sum SHALL be an output, WIDTH bits, the registered result fed to the downstream quantization stage.
REQ-012 Port c_out SHALL be an output, 1 bit, the registered final carry fed to the downstream quantization stage.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ADD and HOLD.
REQ-014 In IDLE with start=1 at an edge, the block SHALL capture a, b and c_in into internal shift and carry registers, clear the bit counter, and enter ADD.
REQ-015 In ADD, each edge SHALL process one bit, LSB first: s = a0^b0^c; carry = majority(a0,b0,c); operand registers shift right; s is shifted into the MSB of the internal sum register; the counter increments.
REQ-016 After exactly WIDTH ADD edges, the block SHALL copy the internal sum and final carry into the sum/c_out output registers and enter HOLD on that same edge.
REQ-017 Latency: if start is sampled at edge N, valid SHALL first be high after edge N+WIDTH.
REQ-018 Result: {c_out,sum} SHALL equal a+b+c_in, computed modulo 2^(WIDTH+1) with no truncation of the carry.
REQ-019 In HOLD, valid SHALL stay high and sum/c_out stay stable until ack=1 is sampled at an edge; at that edge the block SHALL return to IDLE.
REQ-020 sum and c_out SHALL change only on the edge entering HOLD; in IDLE and ADD they SHALL retain the last result.
REQ-021 start in ADD or HOLD SHALL be ignored; operands changing during ADD SHALL NOT affect the result.
REQ-022 If start and ack are both high in HOLD, ack SHALL be honoured and start ignored; a new request requires start high in IDLE.
REQ-023 ack in IDLE or ADD SHALL be ignored.
REQ-024 The minimum issue interval SHALL be WIDTH+2 cycles: start edge, WIDTH add edges, one ack edge.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE and busy=0, valid=0, sum=0, c_out=0, with the counter, operand and carry registers cleared, regardless of clock.
REQ-026 Reset asserted mid-ADD or mid-HOLD SHALL abort the operation without producing any valid pulse.
REQ-027 After rst_n rises, the first start SHALL be accepted at the first rising edge at which it is sampled high.

Verification
REQ-028 a=3, b=4, c_in=0, start pulse, ack tied 1 -> valid high 4 cycles after the start edge with sum=7, c_out=0, for exactly one cycle.
REQ-029 a=9, b=8, c_in=0 -> sum=1, c_out=1 (17), so downstream sees a carry.
REQ-030 a=15, b=15, c_in=1 -> sum=15, c_out=1 (31); busy high for 5 cycles including HOLD.
REQ-031 ack held 0 for 5 cycles after valid rises -> valid, sum and c_out stay constant; ack=1 -> IDLE next edge, and the result is retained with valid=0.
REQ-032 start held high continuously with operands changed during ADD -> only the first operands are summed; a second add starts only after IDLE is re-entered.
REQ-033 rst_n pulsed low after 2 ADD cycles -> outputs are 0 immediately, no valid follows, and a subsequent 2+2 -> sum=4.
